// File: rtl/counter_sweep_controller.sv
// Sweep controller for a 4-bit up/down loadable counter. It steers the counter
// through lo->hi->lo triangle periods, then parks it at lo. Because the counter
// has no enable, the controller freezes it by reloading its own Q when idle.
module counter_sweep_controller #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo_limit,
    input  logic [WIDTH-1:0] hi_limit,
    input  logic [WIDTH-1:0] periods,
    input  logic [WIDTH-1:0] q_in,
    output logic             load,
    output logic [WIDTH-1:0] data,
    output logic             mode_cntrl,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] sweep_count
);

    typedef enum logic [1:0] {StIdle, StLoad, StSweep} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_dir;          // 1 = counting up, 0 = counting down
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_periods;
    logic [WIDTH-1:0] r_sweep_count;
    logic             r_done;
    logic             r_err;

    logic             w_limits_ok;
    logic             w_accept;
    logic             w_reject;
    logic             w_ed;
    logic             w_bottom;
    logic [WIDTH-1:0] w_count_inc;
    logic             w_final;

    assign w_limits_ok = (lo_limit < hi_limit);
    assign w_accept    = start & ~stop & w_limits_ok;
    assign w_reject    = start & ~stop & ~w_limits_ok;
    assign w_bottom    = (r_state == StSweep) & ~r_dir & (q_in <= r_lo);
    assign w_count_inc = r_sweep_count + WIDTH'(1);
    assign w_final     = w_bottom & (r_periods != '0) & (w_count_inc == r_periods);

    assign done        = r_done;
    assign err         = r_err;
    assign sweep_count = r_sweep_count;

    // Effective direction: turn around at either limit, using >=/<= so an
    // out-of-range Q still steers back toward the window.
    always_comb begin
        w_ed = r_dir;
        if (r_dir && (q_in >= r_hi)) begin
            w_ed = 1'b0;
        end else if (!r_dir && (q_in <= r_lo)) begin
            w_ed = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; stop beats everything while busy.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_state_next = stop ? StIdle : StSweep;
            end
            StSweep: begin
                if (stop || w_final) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Counter drive: hold in idle, seed lo in LOAD, steer direction in SWEEP.
    always_comb begin
        load       = 1'b0;
        data       = '0;
        mode_cntrl = 1'b0;
        busy       = (r_state != StIdle);
        case (r_state)
            StIdle: begin
                load       = 1'b1;
                data       = q_in;
                mode_cntrl = 1'b1;
            end
            StLoad: begin
                load = 1'b1;
                data = stop ? q_in : r_lo;
            end
            StSweep: begin
                mode_cntrl = w_ed;
                if (stop) begin
                    load = 1'b1;
                    data = q_in;
                end else if (w_final) begin
                    load = 1'b1;
                    data = r_lo;
                end
            end
            default: begin
                load = 1'b1;
                data = q_in;
            end
        endcase
    end

    // Job registers: latched limits, direction, period count and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir         <= 1'b1;
            r_lo          <= '0;
            r_hi          <= '0;
            r_periods     <= '0;
            r_sweep_count <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= (r_state == StSweep) & ~stop & w_final;
            r_err  <= (r_state == StIdle) & w_reject;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_lo          <= lo_limit;
                        r_hi          <= hi_limit;
                        r_periods     <= periods;
                        r_sweep_count <= '0;
                    end
                end
                StLoad: begin
                    r_dir <= 1'b1;
                end
                StSweep: begin
                    r_dir <= w_ed;
                    if (w_bottom && !stop) begin
                        r_sweep_count <= w_count_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sweep_controller.sv
// Bench for counter_sweep_controller: a behavioural counter closes the loop, a
// job-level model predicts every output each cycle, and directed scenarios pin
// literal values.
module tb_counter_sweep_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] lo_limit = '0;
    logic [3:0] hi_limit = '0;
    logic [3:0] periods = '0;
    logic [3:0] q_in;
    logic       load;
    logic [3:0] data;
    logic       mode_cntrl;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] sweep_count;

    logic [3:0] cnt_q;

    int n_vec = 0;
    int n_mis = 0;

    counter_sweep_controller #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .lo_limit   (lo_limit),
        .hi_limit   (hi_limit),
        .periods    (periods),
        .q_in       (q_in),
        .load       (load),
        .data       (data),
        .mode_cntrl (mode_cntrl),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sweep_count(sweep_count)
    );

    always #5 clk = ~clk;

    // The counter being controlled: sync reset, load, else up/down.
    assign q_in = cnt_q;
    always @(posedge clk) begin
        if (reset)           cnt_q <= 4'd0;
        else if (load)       cnt_q <= data;
        else if (mode_cntrl) cnt_q <= cnt_q + 4'd1;
        else                 cnt_q <= cnt_q - 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job model: a job is a LOAD cycle (k=0) followed by triangle positions
    // k=1,2,... ; Q, direction and period count follow from k by arithmetic.
    bit m_valid = 0;
    bit m_busy = 0;
    bit m_done = 0;
    bit m_err = 0;
    int m_k, m_lo, m_hi, m_n, m_cnt;
    int s, m, eq, shown;
    bit fin;

    always @(negedge clk) begin
        fin = 0;
        shown = 0;
        if (m_valid) begin
            check("m_done", done, m_done);
            check("m_err", err, m_err);
            check("m_busy", busy, m_busy);
            if (!m_busy) begin
                check("m_idle_load", load, 1);
                check("m_idle_data", data, q_in);
                check("m_idle_mode", mode_cntrl, 1);
                check("m_idle_count", sweep_count, m_cnt);
            end else if (m_k == 0) begin
                check("m_ld_load", load, 1);
                check("m_ld_data", data, stop ? q_in : 4'(m_lo));
                if (!stop) check("m_ld_mode", mode_cntrl, 0);
                check("m_ld_count", sweep_count, 0);
            end else begin
                s     = m_hi - m_lo;
                m     = (m_k - 1) % (2 * s);
                eq    = (m <= s) ? m_lo + m : m_lo + 2 * s - m;
                shown = (m_k >= 2) ? ((m_k - 2) / (2 * s)) % 16 : 0;
                fin   = (m_n != 0) && (m_k == 2 * m_n * s + 1);
                check("m_sw_q", q_in, eq);
                check("m_sw_count", sweep_count, shown);
                if (stop) begin
                    check("m_stop_load", load, 1);
                    check("m_stop_data", data, q_in);
                end else begin
                    check("m_sw_mode", mode_cntrl, (m < s) ? 1 : 0);
                    check("m_sw_load", load, fin ? 1 : 0);
                    check("m_sw_data", data, fin ? m_lo : 0);
                end
            end
        end
        if (reset) begin
            m_valid = 1;
            m_busy  = 0;
            m_done  = 0;
            m_err   = 0;
            m_cnt   = 0;
        end else if (m_valid) begin
            m_done = 0;
            m_err  = 0;
            if (!m_busy) begin
                if (start && !stop) begin
                    if (lo_limit < hi_limit) begin
                        m_busy = 1;
                        m_k    = 0;
                        m_lo   = int'(lo_limit);
                        m_hi   = int'(hi_limit);
                        m_n    = int'(periods);
                        m_cnt  = 0;
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (stop) begin
                m_busy = 0;
                m_cnt  = (m_k >= 1) ? shown : 0;
            end else if (m_k >= 1 && fin) begin
                m_busy = 0;
                m_done = 1;
                m_cnt  = m_n;
            end else begin
                m_k++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  seq1[7] = '{2, 3, 4, 5, 4, 3, 2};
    int  seq2[5] = '{4, 5, 4, 5, 4};
    int  cyc;
    bit  found;
    bit  top;

    initial begin
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", sweep_count, 0);
        check("rst_load", load, 1);
        check("rst_data", data, 0);
        check("rst_mode", mode_cntrl, 1);

        // Basic run: lo=2 hi=5 one period, start in cycle 0.
        tick();
        lo_limit = 4'd2; hi_limit = 4'd5; periods = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("basic_ld_load", load, 1);
        check("basic_ld_data", data, 2);
        for (int i = 0; i < 7; i++) begin
            tick();
            @(negedge clk);
            check("basic_q", q_in, seq1[i]);
            if (i == 3) check("basic_top_mode", mode_cntrl, 0);
            if (i == 6) begin
                check("basic_park_load", load, 1);
                check("basic_park_data", data, 2);
            end
        end
        tick();
        @(negedge clk);
        check("basic_done", done, 1);
        check("basic_count", sweep_count, 1);
        tick();
        @(negedge clk);
        check("basic_done_pulse", done, 0);
        check("basic_parked_q", q_in, 2);

        // Multi-period: final reversal 91 cycles after LOAD entry (cycle 1),
        // so done lands in cycle 93 counting the start cycle as 0.
        tick();
        lo_limit = 4'd0; hi_limit = 4'd15; periods = 4'd3; start = 1'b1;
        cyc = -1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
        end
        check("multi_done_cycle", cyc, 93);
        check("multi_count", sweep_count, 3);
        check("multi_parked_q", q_in, 0);

        // Abort while counting up through 6.
        tick();
        lo_limit = 4'd1; hi_limit = 4'd9; periods = 4'd0; start = 1'b1;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            start = 1'b0;
            if (cnt_q == 4'd6) begin
                found = 1;
                break;
            end
        end
        check("abort_reached", found, 1);
        stop = 1'b1;
        @(negedge clk);
        check("abort_load", load, 1);
        check("abort_data", data, 6);
        tick();
        stop = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", q_in, 6);
        tick();
        @(negedge clk);
        check("abort_hold_q", q_in, 6);

        // Start rejection: equal limits, then inverted limits.
        tick();
        lo_limit = 4'd7; hi_limit = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("rej1_err", err, 1);
        check("rej1_busy", busy, 0);
        check("rej1_data", data, 6);
        tick();
        @(negedge clk);
        check("rej1_err_pulse", err, 0);
        tick();
        lo_limit = 4'd9; hi_limit = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("rej2_err", err, 1);
        check("rej2_load", load, 1);
        tick();
        @(negedge clk);
        check("rej2_err_pulse", err, 0);

        // Start+stop together in idle is ignored; then minimum span 4..5.
        tick();
        lo_limit = 4'd4; hi_limit = 4'd5; periods = 4'd2; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        check("coll_busy", busy, 0);
        check("coll_data", data, 6);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("min_ld_data", data, 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("min_q", q_in, seq2[i]);
        end
        tick();
        @(negedge clk);
        check("min_done", done, 1);
        check("min_count", sweep_count, 2);

        // Reset while counting down through 3.
        tick();
        lo_limit = 4'd0; hi_limit = 4'd6; periods = 4'd0; start = 1'b1;
        found = 0;
        top = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            start = 1'b0;
            if (cnt_q == 4'd6) top = 1;
            if (top && cnt_q == 4'd3) begin
                found = 1;
                break;
            end
        end
        check("rstmid_reached", found, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check("rstmid_count", sweep_count, 0);
        check("rstmid_mode", mode_cntrl, 1);
        check("rstmid_data", data, 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
